updown_mod_counter: RTL and testbench
=====================================

# updown_mod_counter

Parametrised synchronous up/down counter, the general-purpose successor to the team's fixed 4-bit binary counter. It has configurable width, modulus, wrap or saturate behaviour, parallel load, synchronous clear and count enable. It provides a terminal-count output for cascading and registered wrap/error flags. It is intended for timers, event counters and address sequencers throughout the design.

## Interface
- WIDTH, 4: counter width in bits; must be ≥ 1.
- MODULO, 16: count range is 0..MODULO-1; 2 ≤ MODULO ≤ 2^WIDTH.
- SATURATE, 0: 0 = wrap at the range ends; 1 = hold at the range ends.
- RESET_VAL, 0: value loaded by reset; must be < MODULO.
- clk  in  1  single clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset; assertion is immediate, release is synchronous to clk.
- en  in  1  count enable.
- up_dn  in  1  direction: 1 = up, 0 = down.
- clr  in  1  synchronous clear to 0.
- load  in  1  synchronous parallel load.
- load_val  in  WIDTH  load value.
- count  out  WIDTH  current count, registered.
- tc  out  1  terminal count, combinational: en && count at the range end for the current direction.
- wrap  out  1  registered one-cycle pulse after a wrap event.
- at_zero  out  1  combinational: count == 0.
- load_err  out  1  registered one-cycle pulse after an out-of-range load.

## Operation
- Range end for the current direction:
  - up: MODULO-1
  - down: 0
- Per-edge priority, evaluated on each rising edge with reset high:
  1. clr: count ← 0. Also wins over load and en.
  2. load: if load_val < MODULO, count ← load_val. Otherwise count ← MODULO-1 and load_err ← 1.
  3. en with up_dn=1:
     - count < MODULO-1: count ← count+1.
     - count = MODULO-1, SATURATE=0: count ← 0 and wrap ← 1.
     - count = MODULO-1, SATURATE=1: count holds; wrap stays 0.
  4. en with up_dn=0:
     - count > 0: count ← count-1.
     - count = 0, SATURATE=0: count ← MODULO-1 and wrap ← 1.
     - count = 0, SATURATE=1: count holds.
  5. Otherwise count holds.
- wrap and load_err are 0 on every edge where their condition is not met. They are strictly one-cycle pulses.
- Arithmetic: the increment/decrement is computed in WIDTH+1 bits, so there is no silent overflow when MODULO = 2^WIDTH. count never leaves 0..MODULO-1.
- tc is independent of SATURATE. It is asserted even when SATURATE=1 and the count will hold, so cascaded stages see a carry/borrow request.
- Cascading: the next stage's en is driven from this stage's tc. The next stage's up_dn must match this stage's.

## Timing
- Reset asserted (reset=0), asynchronously and without waiting for clk:
  - count = RESET_VAL
  - wrap = 0, load_err = 0
  - tc and at_zero follow from count and en
- First state change occurs on the first rising edge with reset=1.
- Latency:
  - count reflects clr/load/en one edge after the edge where they are sampled.
  - wrap and load_err assert in the same cycle that count shows the new value.
  - tc and at_zero are combinational from the current count, en and up_dn; zero latency.
- Reset asserted mid-count or mid-pulse: all registered outputs clear immediately. Any pending wrap/load_err pulse is lost.
- Changing direction (up_dn) takes effect on the next edge; there is no extra cycle.

## Test plan
- Reset mid-operation: WIDTH=4, MODULO=16, RESET_VAL=0; count at 9 with en=1; drive reset=0 between edges -> count=0 and wrap=0 before the next edge. With reset released, the first edge gives count=1.
- Modulo-10 up wrap: MODULO=10, SATURATE=0, en=1, up_dn=1, from 0 -> count 0,1,…,9,0. tc=1 only while count=9. wrap=1 for exactly the one cycle in which count shows 0. at_zero=1 in that same cycle.
- Down wrap and saturate:
  - MODULO=10, count=0, up_dn=0, en=1, SATURATE=0 -> count=9, wrap pulse.
  - Same stimulus with SATURATE=1 -> count stays 0, wrap=0, tc=1.
- Out-of-range load: MODULO=10, load=1, load_val=12 -> count=9 and a one-cycle load_err. Then load_val=5 -> count=5, load_err=0.
- Priority: count=7, clr=1, load=1 with load_val=3, en=1 on the same edge -> count=0, no wrap, no load_err. With clr=0 and load=1, en=1 -> count=3.
- Full-range cascade: two instances, WIDTH=4, MODULO=16, stage 1 en = stage 0 tc; run 256 cycles up -> combined value 255→0 and a stage-1 wrap pulse. Then en=0 for 5 cycles -> count holds.

Source files
------------

// File: rtl/updown_mod_counter.sv
// updown_mod_counter: parametrised up/down modulo counter with wrap or saturate, load, clear,
// terminal count for cascading and registered wrap / load_err pulses
module updown_mod_counter #(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned MODULO    = 16,
  parameter bit          SATURATE  = 1'b0,
  parameter int unsigned RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up_dn,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap,
  output logic             at_zero,
  output logic             load_err
);
  // one extra bit keeps MODULO = 2^WIDTH representable and the +1 free of overflow
  localparam logic [WIDTH:0] ONE   = 1;
  localparam logic [WIDTH:0] MOD_W = MODULO[WIDTH:0];
  localparam logic [WIDTH:0] TOP   = MOD_W - ONE;
  logic [WIDTH:0] cur, nxt, lv;
  logic           at_top, wrap_nx, err_nx;
  assign cur     = {1'b0, count};
  assign lv      = {1'b0, load_val};
  assign at_top  = cur == TOP;
  assign at_zero = count == '0;
  assign tc      = en && (up_dn ? at_top : at_zero);
  always_comb begin
    nxt     = cur;
    wrap_nx = 1'b0;
    err_nx  = 1'b0;
    if (clr) begin
      nxt = '0;
    end else if (load) begin
      err_nx = lv >= MOD_W;
      nxt    = err_nx ? TOP : lv;
    end else if (en && up_dn) begin
      if (!at_top) nxt = cur + ONE;
      else if (!SATURATE) begin
        nxt     = '0;
        wrap_nx = 1'b1;
      end
    end else if (en) begin
      if (!at_zero) nxt = cur - ONE;
      else if (!SATURATE) begin
        nxt     = TOP;
        wrap_nx = 1'b1;
      end
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count    <= RESET_VAL[WIDTH-1:0];
      wrap     <= 1'b0;
      load_err <= 1'b0;
    end else begin
      count    <= nxt[WIDTH-1:0];
      wrap     <= wrap_nx;
      load_err <= err_nx;
    end
  end
endmodule

// File: tb/tb_updown_mod_counter.sv
// tb_updown_mod_counter: vector table, corner sequences, random stimulus against an arithmetic model
module tb_updown_mod_counter;
  logic clk = 0, reset = 0, en = 0, up_dn = 1, clr = 0, load = 0;
  logic [3:0] load_val = 0;
  logic [3:0] q16, q10, qs;
  logic tc16, tc10, tcs, w16, w10, ws, z16, z10, zs, e16, e10, es;
  logic ce = 0, cup = 1;
  logic [3:0] k0, k1;
  logic t0, t1, kw0, kw1, kz0, kz1, ke0, ke1;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  updown_mod_counter #(.WIDTH(4), .MODULO(16), .SATURATE(0), .RESET_VAL(0)) d16 (
    .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .clr(clr), .load(load), .load_val(load_val),
    .count(q16), .tc(tc16), .wrap(w16), .at_zero(z16), .load_err(e16));
  updown_mod_counter #(.WIDTH(4), .MODULO(10), .SATURATE(0), .RESET_VAL(0)) d10 (
    .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .clr(clr), .load(load), .load_val(load_val),
    .count(q10), .tc(tc10), .wrap(w10), .at_zero(z10), .load_err(e10));
  updown_mod_counter #(.WIDTH(4), .MODULO(10), .SATURATE(1), .RESET_VAL(3)) s10 (
    .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .clr(clr), .load(load), .load_val(load_val),
    .count(qs), .tc(tcs), .wrap(ws), .at_zero(zs), .load_err(es));
  updown_mod_counter #(.WIDTH(4), .MODULO(16), .SATURATE(0), .RESET_VAL(0)) c0 (
    .clk(clk), .reset(reset), .en(ce), .up_dn(cup), .clr(1'b0), .load(1'b0), .load_val(4'd0),
    .count(k0), .tc(t0), .wrap(kw0), .at_zero(kz0), .load_err(ke0));
  updown_mod_counter #(.WIDTH(4), .MODULO(16), .SATURATE(0), .RESET_VAL(0)) c1 (
    .clk(clk), .reset(reset), .en(t0), .up_dn(cup), .clr(1'b0), .load(1'b0), .load_val(4'd0),
    .count(k1), .tc(t1), .wrap(kw1), .at_zero(kz1), .load_err(ke1));

  typedef struct {int c; bit w; bit e;} st_t;
  typedef struct {bit c_i; bit l_i; bit e_i; bit u_i; int lv; int c; bit w; bit e;} vec_t;
  st_t m16, m10, ms;
  vec_t tbl[$];

  // next state from the counting rules: step within 0..m-1, out-of-range means wrap or hold
  function automatic st_t model(st_t s, int m, bit sat, bit c_i, bit l_i, bit e_i, bit u_i, int lv);
    st_t r;
    int t;
    r = '{s.c, 1'b0, 1'b0};
    t = s.c + (u_i ? 1 : -1);
    if (c_i) r.c = 0;
    else if (l_i) begin
      r.e = lv >= m;
      r.c = r.e ? m - 1 : lv;
    end else if (e_i && (t < 0 || t >= m)) begin
      if (!sat) begin
        r.c = (t + m) % m;
        r.w = 1'b1;
      end
    end else if (e_i) r.c = t;
    return r;
  endfunction

  task automatic cmp(string n, logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", n, a, e);
    end
  endtask

  task automatic chk_reg(string n, logic [3:0] q, logic w, logic e, st_t m);
    cmp({n, ".count"}, 32'(q), m.c);
    cmp({n, ".wrap"}, 32'(w), 32'(m.w));
    cmp({n, ".load_err"}, 32'(e), 32'(m.e));
  endtask

  task automatic chk_comb(string n, logic t, logic z, st_t m, int mod);
    cmp({n, ".tc"}, 32'(t), 32'(en && (up_dn ? m.c == mod - 1 : m.c == 0)));
    cmp({n, ".at_zero"}, 32'(z), 32'(m.c == 0));
  endtask

  task automatic chk_all_reg();
    chk_reg("d16", q16, w16, e16, m16);
    chk_reg("d10", q10, w10, e10, m10);
    chk_reg("s10", qs, ws, es, ms);
  endtask

  task automatic step(bit c_i, bit l_i, bit e_i, bit u_i, int lv);
    clr = c_i; load = l_i; en = e_i; up_dn = u_i; load_val = lv[3:0];
    #1;
    chk_comb("d16", tc16, z16, m16, 16);
    chk_comb("d10", tc10, z10, m10, 10);
    chk_comb("s10", tcs, zs, ms, 10);
    @(posedge clk);
    m16 = model(m16, 16, 0, c_i, l_i, e_i, u_i, lv);
    m10 = model(m10, 10, 0, c_i, l_i, e_i, u_i, lv);
    ms  = model(ms, 10, 1, c_i, l_i, e_i, u_i, lv);
    #1;
    chk_all_reg();
  endtask

  // asserted between edges: outputs must clear without waiting for clk
  task automatic do_reset();
    reset = 0;
    #1;
    m16 = '{0, 0, 0}; m10 = '{0, 0, 0}; ms = '{3, 0, 0};
    chk_all_reg();
    cmp("casc.reset", 32'({k1, k0}), 0);
    reset = 1;
  endtask

  initial begin
    m16 = '{0, 0, 0}; m10 = '{0, 0, 0}; ms = '{3, 0, 0};
    repeat (2) @(posedge clk);
    #1;
    chk_all_reg();
    cmp("reset.at_zero16", 32'(z16), 1);
    cmp("reset.tc_en0", 32'(tcs), 0);
    cmp("casc.reset", 32'({k1, k0}), 0);
    reset = 1;

    // d10 vectors: {clr, load, en, up, load_val, count, wrap, load_err}
    tbl.push_back(vec_t'{0, 1, 0, 0, 12, 9, 0, 1});
    tbl.push_back(vec_t'{0, 1, 0, 0, 5, 5, 0, 0});
    tbl.push_back(vec_t'{0, 0, 1, 1, 0, 6, 0, 0});
    tbl.push_back(vec_t'{0, 0, 1, 1, 0, 7, 0, 0});
    tbl.push_back(vec_t'{1, 1, 1, 1, 3, 0, 0, 0});
    tbl.push_back(vec_t'{0, 1, 1, 1, 3, 3, 0, 0});
    tbl.push_back(vec_t'{0, 0, 1, 0, 0, 2, 0, 0});
    tbl.push_back(vec_t'{0, 0, 1, 0, 0, 1, 0, 0});
    tbl.push_back(vec_t'{0, 0, 1, 0, 0, 0, 0, 0});
    tbl.push_back(vec_t'{0, 0, 1, 0, 0, 9, 1, 0});
    tbl.push_back(vec_t'{0, 0, 0, 0, 0, 9, 0, 0});
    tbl.push_back(vec_t'{0, 0, 1, 1, 0, 0, 1, 0});
    tbl.push_back(vec_t'{0, 1, 0, 1, 15, 9, 0, 1});
    tbl.push_back(vec_t'{0, 1, 0, 1, 10, 9, 0, 1});
    tbl.push_back(vec_t'{0, 1, 0, 1, 9, 9, 0, 0});
    tbl.push_back(vec_t'{0, 0, 1, 1, 0, 0, 1, 0});
    foreach (tbl[i]) begin
      step(tbl[i].c_i, tbl[i].l_i, tbl[i].e_i, tbl[i].u_i, tbl[i].lv);
      cmp($sformatf("vec%0d.count", i), 32'(q10), tbl[i].c);
      cmp($sformatf("vec%0d.wrap", i), 32'(w10), 32'(tbl[i].w));
      cmp($sformatf("vec%0d.load_err", i), 32'(e10), 32'(tbl[i].e));
    end

    // full modulo-10 up sweep
    step(1, 0, 0, 1, 0);
    for (int i = 1; i <= 10; i++) begin
      step(0, 0, 1, 1, 0);
      cmp($sformatf("sweep%0d.count", i), 32'(q10), i % 10);
      cmp($sformatf("sweep%0d.wrap", i), 32'(w10), 32'(i == 10));
      cmp($sformatf("sweep%0d.at_zero", i), 32'(z10), 32'(i == 10));
    end

    // down from 0: wrap vs saturate
    step(1, 0, 0, 1, 0);
    step(0, 0, 1, 0, 0);
    cmp("down.wrap_count", 32'(q10), 9);
    cmp("down.wrap_pulse", 32'(w10), 1);
    cmp("down.sat_count", 32'(qs), 0);
    cmp("down.sat_wrap", 32'(ws), 0);
    cmp("down.sat_tc", 32'(tcs), 1);

    // reset mid-count, then mid load_err pulse
    step(1, 0, 0, 1, 0);
    for (int i = 0; i < 9; i++) step(0, 0, 1, 1, 0);
    cmp("midreset.pre", 32'(q16), 9);
    do_reset();
    step(0, 0, 1, 1, 0);
    cmp("midreset.first_edge", 32'(q16), 1);
    step(0, 1, 0, 0, 12);
    cmp("midpulse.pre", 32'(e10), 1);
    do_reset();

    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 15) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0,
           1'($urandom_range(0, 1)), $urandom_range(0, 15));

    // two-stage cascade over the full 256 range
    clr = 0; load = 0; en = 0;
    cmp("casc.start", 32'({k1, k0}), 0);
    ce = 1; cup = 1;
    for (int k = 1; k <= 256; k++) begin
      @(posedge clk);
      #1;
      cmp($sformatf("casc%0d.value", k), 32'({k1, k0}), k % 256);
      cmp($sformatf("casc%0d.wrap1", k), 32'(kw1), 32'(k == 256));
    end
    ce = 0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      cmp($sformatf("hold%0d.value", k), 32'({k1, k0}), 0);
      cmp($sformatf("hold%0d.wrap1", k), 32'(kw1), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
